priority_enc_arb: RTL and testbench

- Parametrised, registered N-input priority encoder/arbiter with grant lock. Generalises the 4:2 combinational priority encoder in three ways: N inputs, selectable fixed or round-robin priority, and grant hold until release.
- Sits in front of a shared resource. Requesters assert req bits. The block registers one winner and outputs it both one-hot and binary-encoded. The grant holds until the owner pulses done.

---
 rtl/priority_enc_arb.sv | 117 +++++++++++
 tb/tb_priority_enc_arb.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/priority_enc_arb.sv
// Registered N-input priority arbiter with grant lock: fixed (highest index wins)
// or round-robin priority; a grant is held until its owner pulses done.
//
// state | meaning
// IDLE  | no grant held; arbitrate whenever en=1 and req is non-zero
// BUSY  | grant held; done releases it and re-arbitrates in the same cycle
module priority_enc_arb #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N),
    parameter bit RR    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0] ptr_rel, ptr_eff, win;
    logic [N-1:0]     grant_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             valid_nxt;
    logic             release_now;
    int               pos;

    assign release_now = (state == BUSY) && done;

    // Wrap at N, not at 2^IDX_W, so non-power-of-2 N stays in range.
    assign ptr_rel = (idx == IDX_W'(N - 1)) ? '0 : idx + IDX_W'(1);

    // A release makes the releasing requester lowest priority in the same-cycle search.
    assign ptr_eff = release_now ? ptr_rel : rr_ptr;

    always_comb begin
        win = '0;
        pos = 0;
        if (RR) begin
            // Walk from farthest to nearest so the bit closest to ptr_eff wins last.
            for (int off = N - 1; off >= 0; off--) begin
                pos = int'(ptr_eff) + off;
                if (pos >= N) pos = pos - N;
                if (req[IDX_W'(pos)]) win = IDX_W'(pos);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (req[IDX_W'(k)]) win = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        idx_nxt    = idx;
        valid_nxt  = valid;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (en && (|req)) begin
                    grant_nxt = {{(N-1){1'b0}}, 1'b1} << win;
                    idx_nxt   = win;
                    valid_nxt = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    if (RR) rr_ptr_nxt = ptr_rel;
                    if (en && (|req)) begin
                        grant_nxt = {{(N-1){1'b0}}, 1'b1} << win;
                        idx_nxt   = win;
                        valid_nxt = 1'b1;
                    end else begin
                        grant_nxt = '0;
                        idx_nxt   = '0;
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                grant_nxt  = '0;
                idx_nxt    = '0;
                valid_nxt  = 1'b0;
                rr_ptr_nxt = '0;
                state_nxt  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            idx    <= '0;
            valid  <= 1'b0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            idx    <= idx_nxt;
            valid  <= valid_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_priority_enc_arb.sv
// Directed bench for priority_enc_arb: fixed-priority N=8, round-robin N=4 and N=5
// instances driven side by side, checked with immediate assertions.
module tb_priority_enc_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       en8 = 1'b0, done8 = 1'b0;
    logic [7:0] req8 = '0, grant8;
    logic [2:0] idx8;
    logic       valid8;

    logic       en4 = 1'b0, done4 = 1'b0;
    logic [3:0] req4 = '0, grant4;
    logic [1:0] idx4;
    logic       valid4;

    logic       en5 = 1'b0, done5 = 1'b0;
    logic [4:0] req5 = '0, grant5;
    logic [2:0] idx5;
    logic       valid5;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    priority_enc_arb #(.N(8), .RR(1'b0)) u8 (
        .clk(clk), .rst(rst), .en(en8), .req(req8), .done(done8),
        .grant(grant8), .idx(idx8), .valid(valid8));

    priority_enc_arb #(.N(4), .RR(1'b1)) u4 (
        .clk(clk), .rst(rst), .en(en4), .req(req4), .done(done4),
        .grant(grant4), .idx(idx4), .valid(valid4));

    priority_enc_arb #(.N(5), .RR(1'b1)) u5 (
        .clk(clk), .rst(rst), .en(en5), .req(req5), .done(done5),
        .grant(grant5), .idx(idx5), .valid(valid5));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_rr[4];
        exp_rr[0] = 1; exp_rr[1] = 2; exp_rr[2] = 3; exp_rr[3] = 0;

        // Reset and idle
        tick(); tick();
        rst = 1'b0; en8 = 1'b1; req8 = '0;
        tick();
        chk("idle_grant8", 32'(grant8), 32'h0);
        chk("idle_idx8",   32'(idx8),   32'h0);
        chk("idle_valid8", 32'(valid8), 32'h0);
        chk("idle_valid4", 32'(valid4), 32'h0);
        chk("idle_valid5", 32'(valid5), 32'h0);

        // Fixed priority: highest index wins, 1-cycle latency
        req8 = 8'b0010_0110;
        tick();
        chk("fix_grant", 32'(grant8), 32'h20);
        chk("fix_idx",   32'(idx8),   32'd5);
        chk("fix_valid", 32'(valid8), 32'h1);
        req8 = '0;
        tick();
        chk("hold_noreq_grant", 32'(grant8), 32'h20);
        chk("hold_noreq_idx",   32'(idx8),   32'd5);
        done8 = 1'b1;
        tick();
        done8 = 1'b0;
        chk("release_valid", 32'(valid8), 32'h0);
        chk("release_grant", 32'(grant8), 32'h0);
        chk("release_idx",   32'(idx8),   32'h0);

        // Back-to-back handoff in fixed mode
        req8 = 8'b0010_0110;
        tick();
        chk("b2b_first_idx", 32'(idx8), 32'd5);
        done8 = 1'b1;
        tick();
        done8 = 1'b0;
        chk("b2b_rewin_idx",   32'(idx8),   32'd5);
        chk("b2b_rewin_valid", 32'(valid8), 32'h1);
        req8 = 8'b0000_0110; done8 = 1'b1;
        tick();
        done8 = 1'b0;
        chk("b2b_next_idx",   32'(idx8),   32'd2);
        chk("b2b_next_grant", 32'(grant8), 32'h04);
        chk("b2b_next_valid", 32'(valid8), 32'h1);
        tick();
        chk("b2b_hold_idx", 32'(idx8), 32'd2);

        // Release to idle, then enable gating
        req8 = '0; done8 = 1'b1;
        tick();
        done8 = 1'b0;
        chk("to_idle_valid", 32'(valid8), 32'h0);
        en8 = 1'b0; req8 = 8'hFF;
        tick(); tick();
        chk("en0_grant", 32'(grant8), 32'h0);
        chk("en0_valid", 32'(valid8), 32'h0);
        en8 = 1'b1;
        tick();
        chk("en1_idx",   32'(idx8),   32'd7);
        chk("en1_grant", 32'(grant8), 32'h80);
        en8 = 1'b0;
        tick();
        chk("en0_busy_hold", 32'(idx8), 32'd7);

        // Round-robin fairness, N=4, done every 3rd cycle
        en4 = 1'b1; req4 = 4'b1111;
        tick();
        chk("rr4_first_idx", 32'(idx4), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr4_hold_a", 32'(idx4), 32'(i == 0 ? 0 : exp_rr[i-1]));
            tick();
            chk("rr4_hold_b", 32'(idx4), 32'(i == 0 ? 0 : exp_rr[i-1]));
            done4 = 1'b1;
            tick();
            done4 = 1'b0;
            chk("rr4_next_idx",   32'(idx4),   32'(exp_rr[i]));
            chk("rr4_next_valid", 32'(valid4), 32'h1);
        end
        done4 = 1'b1;
        tick();
        done4 = 1'b0;
        chk("rr4_extra_idx", 32'(idx4), 32'd1);
        chk("rr4_ptr_before_rst", 32'(u4.rr_ptr), 32'd1);

        // Round-robin wrap at N=5 with sparse requests
        en5 = 1'b1; req5 = 5'b10000;
        tick();
        chk("rr5_owner_idx", 32'(idx5), 32'd4);
        req5 = 5'b10010; done5 = 1'b1;
        tick();
        chk("rr5_wrap_idx", 32'(idx5),      32'd1);
        chk("rr5_wrap_ptr", 32'(u5.rr_ptr), 32'd0);
        tick();
        done5 = 1'b0;
        chk("rr5_next_idx",   32'(idx5),      32'd4);
        chk("rr5_next_ptr",   32'(u5.rr_ptr), 32'd2);
        chk("rr5_next_grant", 32'(grant5),    32'h10);

        // Reset while busy with done asserted: reset wins
        rst = 1'b1; done8 = 1'b1; en8 = 1'b1; done4 = 1'b1;
        tick();
        rst = 1'b0; done8 = 1'b0; done4 = 1'b0; req8 = '0; req4 = '0;
        chk("rst_grant8", 32'(grant8),    32'h0);
        chk("rst_idx8",   32'(idx8),      32'h0);
        chk("rst_valid8", 32'(valid8),    32'h0);
        chk("rst_valid4", 32'(valid4),    32'h0);
        chk("rst_ptr4",   32'(u4.rr_ptr), 32'h0);
        tick();
        chk("post_rst_valid8", 32'(valid8), 32'h0);
        req4 = 4'b1010;
        tick();
        chk("post_rst_rr4_idx", 32'(idx4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
